// File: rtl/cvw_arch_verif_if.sv
// Retired-instruction record bus feeding the architectural coverage monitor.
// The retiring pipeline drives the record (master); the monitor observes it (slave).
interface cvw_arch_verif_if #(
  parameter int XLEN = 64
);
  logic            valid;
  logic [63:0]     order;
  logic [31:0]     insn;
  logic            trap;
  logic [XLEN-1:0] pc_rdata;
  logic [1:0]      mode;
  logic [31:0]     x_wb;
  logic [31:0]     f_wb;

  modport master (
    output valid, order, insn, trap, pc_rdata, mode, x_wb, f_wb
  );

  modport slave (
    input valid, order, insn, trap, pc_rdata, mode, x_wb, f_wb
  );
endinterface

// File: rtl/cvw_arch_verif.sv
// Architectural coverage monitor: counts retired/trapped records, accumulates sticky hit maps and error flags.
// Define COVER_FREG_EN to accumulate FP register write-back coverage in freg_hit.
module cvw_arch_verif #(
  parameter int XLEN = 64,
  parameter int FLEN = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  cvw_arch_verif_if.slave       rec,
  output logic [31:0]           retired_cnt,
  output logic [31:0]           trap_cnt,
  output logic [3:0]            mode_hit,
  output logic [31:0]           opcode_hit,
  output logic [2:0]            comp_hit,
  output logic [31:0]           xreg_hit,
  output logic [31:0]           freg_hit,
  output logic                  order_err,
  output logic                  x0_err,
  output logic                  pc_err,
  output logic                  mode_err
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [63:0] last_order;
  logic        seen_first;

  // Per-record accounting; everything holds while valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= '0;
      trap_cnt    <= '0;
      mode_hit    <= '0;
      opcode_hit  <= '0;
      comp_hit    <= '0;
      xreg_hit    <= '0;
      order_err   <= 1'b0;
      x0_err      <= 1'b0;
      pc_err      <= 1'b0;
      mode_err    <= 1'b0;
      last_order  <= '0;
      seen_first  <= 1'b0;
    end else if (rec.valid) begin
      mode_hit[rec.mode] <= 1'b1;
      if (rec.mode == 2'd2) mode_err <= 1'b1;
      if (rec.x_wb[0]) x0_err <= 1'b1;
      if (rec.pc_rdata[0]) pc_err <= 1'b1;

      // The first record only seeds the sequence; every record recaptures it.
      seen_first <= 1'b1;
      last_order <= rec.order;
      if (seen_first && (rec.order != last_order + 64'd1)) order_err <= 1'b1;

      if (rec.trap) begin
        if (trap_cnt != CNT_MAX) trap_cnt <= trap_cnt + 32'd1;
      end else begin
        if (retired_cnt != CNT_MAX) retired_cnt <= retired_cnt + 32'd1;
        if (rec.insn[1:0] == 2'b11) opcode_hit[rec.insn[6:2]] <= 1'b1;
        else                        comp_hit[rec.insn[1:0]]   <= 1'b1;
        xreg_hit <= xreg_hit | {rec.x_wb[31:1], 1'b0};
      end
    end
  end

`ifdef COVER_FREG_EN
  // FP coverage includes f0, which unlike x0 is a real register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freg_hit <= '0;
    end else if (rec.valid && !rec.trap) begin
      freg_hit <= freg_hit | rec.f_wb;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{rec.pc_rdata[XLEN-1:1], rec.insn[31:7], FLEN[0]};
`else
  assign freg_hit = '0;

  logic unused_bits;
  assign unused_bits = ^{rec.pc_rdata[XLEN-1:1], rec.insn[31:7], rec.f_wb, FLEN[0]};
`endif

endmodule

// File: tb/tb_cvw_arch_verif.sv
// Directed bench for cvw_arch_verif: a reference model pushes expected snapshots to a scoreboard queue.
// Build with COVER_FREG_EN defined to exercise FP register coverage.
module tb_cvw_arch_verif;

  localparam int XLEN = 64;

  typedef struct {
    logic [31:0] retired;
    logic [31:0] traps;
    logic [3:0]  mode;
    logic [31:0] opcode;
    logic [2:0]  comp;
    logic [31:0] xreg;
    logic [31:0] freg;
    logic        order_err;
    logic        x0_err;
    logic        pc_err;
    logic        mode_err;
  } snap_t;

  logic        clk;
  logic        reset;
  logic [31:0] retired_cnt, trap_cnt, opcode_hit, xreg_hit, freg_hit;
  logic [3:0]  mode_hit;
  logic [2:0]  comp_hit;
  logic        order_err, x0_err, pc_err, mode_err;

  int tests_run;
  int tests_failed;

  snap_t       model;
  logic        m_first;
  logic [63:0] m_order;
  snap_t       sb[$];

  cvw_arch_verif_if #(.XLEN(XLEN)) rec ();

  cvw_arch_verif #(.XLEN(XLEN), .FLEN(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .rec         (rec),
    .retired_cnt (retired_cnt),
    .trap_cnt    (trap_cnt),
    .mode_hit    (mode_hit),
    .opcode_hit  (opcode_hit),
    .comp_hit    (comp_hit),
    .xreg_hit    (xreg_hit),
    .freg_hit    (freg_hit),
    .order_err   (order_err),
    .x0_err      (x0_err),
    .pc_err      (pc_err),
    .mode_err    (mode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    model = '{default: '0};
    m_first = 1'b1;
    m_order = '0;
  endtask

  // Pops the oldest expected snapshot and compares every output against it.
  task automatic checkOutput(input string step);
    snap_t e;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", step);
      return;
    end
    e = sb.pop_front();
    checkVal({step, ".retired_cnt"}, retired_cnt, e.retired);
    checkVal({step, ".trap_cnt"},    trap_cnt,    e.traps);
    checkVal({step, ".mode_hit"},    {28'b0, mode_hit}, {28'b0, e.mode});
    checkVal({step, ".opcode_hit"},  opcode_hit,  e.opcode);
    checkVal({step, ".comp_hit"},    {29'b0, comp_hit}, {29'b0, e.comp});
    checkVal({step, ".xreg_hit"},    xreg_hit,    e.xreg);
    checkVal({step, ".freg_hit"},    freg_hit,    e.freg);
    checkVal({step, ".order_err"},   {31'b0, order_err}, {31'b0, e.order_err});
    checkVal({step, ".x0_err"},      {31'b0, x0_err},    {31'b0, e.x0_err});
    checkVal({step, ".pc_err"},      {31'b0, pc_err},    {31'b0, e.pc_err});
    checkVal({step, ".mode_err"},    {31'b0, mode_err},  {31'b0, e.mode_err});
  endtask

  // Called at a falling edge: drives one record, predicts its effect, checks after the next rising edge.
  task automatic applyStimulus(input string step, input logic [63:0] ord, input logic [31:0] ins,
                               input logic tr, input logic [XLEN-1:0] pc, input logic [1:0] md,
                               input logic [31:0] xw, input logic [31:0] fw);
    rec.valid = 1'b1; rec.order = ord; rec.insn = ins; rec.trap = tr;
    rec.pc_rdata = pc; rec.mode = md; rec.x_wb = xw; rec.f_wb = fw;

    model.mode = model.mode | (4'b1 << md);
    if (md == 2'd2) model.mode_err = 1'b1;
    if (xw[0]) model.x0_err = 1'b1;
    if (pc[0]) model.pc_err = 1'b1;
    if (!m_first && ord != m_order + 64'd1) model.order_err = 1'b1;
    m_first = 1'b0;
    m_order = ord;
    if (tr) begin
      if (model.traps != 32'hFFFF_FFFF) model.traps = model.traps + 1;
    end else begin
      if (model.retired != 32'hFFFF_FFFF) model.retired = model.retired + 1;
      if (ins[1:0] == 2'b11) model.opcode = model.opcode | (32'h1 << ins[6:2]);
      else                   model.comp   = model.comp | (3'b1 << ins[1:0]);
      model.xreg = model.xreg | (xw & 32'hFFFF_FFFE);
`ifdef COVER_FREG_EN
      model.freg = model.freg | fw;
`endif
    end
    sb.push_back(model);

    @(posedge clk);
    #1;
    rec.valid = 1'b0;
    checkOutput(step);
  endtask

  // Idle cycle with junk on the record fields: nothing may change.
  task automatic idleCycle(input string step);
    @(negedge clk);
    rec.valid = 1'b0; rec.trap = 1'b1; rec.mode = 2'd2; rec.x_wb = '1;
    rec.f_wb = '1; rec.pc_rdata = '1; rec.insn = 32'h0000_0013; rec.order = 64'd77;
    sb.push_back(model);
    @(posedge clk);
    #1;
    checkOutput(step);
  endtask

  // Reset pulse placed between clock edges; outputs must clear before any edge.
  task automatic pulseReset(input string step);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    sb.push_back(model);
    checkOutput(step);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] op_tbl [4];
    logic [31:0] xw_tbl [4];
    logic [1:0]  md_tbl [4];

    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    rec.valid = 1'b0; rec.order = '0; rec.insn = '0; rec.trap = 1'b0;
    rec.pc_rdata = '0; rec.mode = '0; rec.x_wb = '0; rec.f_wb = '0;
    modelReset();

    #1;
    sb.push_back(model);
    checkOutput("reset_state");

    // Reset released in the same cycle the first record is presented.
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("seq1", 64'd1, 32'h0000_0013, 1'b0, 64'h8000_0000, 2'd3, 32'h0, 32'h0);
    @(negedge clk);
    applyStimulus("seq2", 64'd2, 32'h0000_0013, 1'b0, 64'h8000_0004, 2'd3, 32'h0, 32'h0);
    @(negedge clk);
    applyStimulus("seq3", 64'd3, 32'h0000_0013, 1'b0, 64'h8000_0008, 2'd3, 32'h0, 32'h0);
    checkVal("addi_retired", retired_cnt, 32'd3);
    checkVal("addi_opcode",  opcode_hit,  32'h0000_0010);
    checkVal("addi_mode",    {28'b0, mode_hit}, 32'h8);
    checkVal("addi_order_ok", {31'b0, order_err}, 32'h0);

    idleCycle("hold");

    pulseReset("reset_mid1");
    @(negedge clk);
    applyStimulus("ord5", 64'd5, 32'h0000_0013, 1'b0, 64'h8000_0000, 2'd3, 32'h0, 32'h0);
    checkVal("first_no_err", {31'b0, order_err}, 32'h0);
    @(negedge clk);
    applyStimulus("ord7", 64'd7, 32'h0000_0013, 1'b0, 64'h8000_0004, 2'd3, 32'h0, 32'h0);
    checkVal("gap_err", {31'b0, order_err}, 32'h1);
    @(negedge clk);
    applyStimulus("ord8", 64'd8, 32'h0000_0013, 1'b0, 64'h8000_0008, 2'd3, 32'h0, 32'h0);
    checkVal("gap_sticky", {31'b0, order_err}, 32'h1);

    @(negedge clk);
    applyStimulus("ecall", 64'd9, 32'h0000_0073, 1'b1, 64'h8000_000c, 2'd3, 32'h0, 32'h0);
    checkVal("trap_cnt",      trap_cnt,    32'd1);
    checkVal("trap_retired",  retired_cnt, 32'd3);
    checkVal("trap_opcode28", {31'b0, opcode_hit[28]}, 32'h0);

    @(negedge clk);
    applyStimulus("cli", 64'd10, 32'h0000_4501, 1'b0, 64'h8000_0010, 2'd0, 32'h0000_0401, 32'h0);
    checkVal("cli_comp", {29'b0, comp_hit}, 32'h2);
    checkVal("cli_xreg", xreg_hit, 32'h0000_0400);
    checkVal("cli_x0err", {31'b0, x0_err}, 32'h1);

    @(negedge clk);
    applyStimulus("fwb", 64'd11, 32'h0000_0053, 1'b0, 64'h8000_0012, 2'd1, 32'h0, 32'h0000_0003);
`ifdef COVER_FREG_EN
    checkVal("fwb_freg", freg_hit, 32'h0000_0003);
`else
    checkVal("fwb_freg", freg_hit, 32'h0000_0000);
`endif

    pulseReset("reset_mid2");
    @(negedge clk);
    applyStimulus("oddpc", 64'd20, 32'h0000_0013, 1'b0, 64'h8000_0001, 2'd2, 32'h0, 32'h0);
    checkVal("oddpc_pcerr",  {31'b0, pc_err},   32'h1);
    checkVal("oddpc_moderr", {31'b0, mode_err}, 32'h1);
    checkVal("oddpc_mode",   {28'b0, mode_hit}, 32'h4);
    pulseReset("reset_mid3");

    // After a mid-run reset the next record is treated as first again.
    op_tbl[0] = 32'h0000_2003; xw_tbl[0] = 32'h0000_0020; md_tbl[0] = 2'd1;
    op_tbl[1] = 32'h0080_006F; xw_tbl[1] = 32'h0000_0002; md_tbl[1] = 2'd3;
    op_tbl[2] = 32'h0000_8082; xw_tbl[2] = 32'h8000_0000; md_tbl[2] = 2'd0;
    op_tbl[3] = 32'h1234_50B7; xw_tbl[3] = 32'h0000_0003; md_tbl[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus($sformatf("mix%0d", i), 64'hFFFF_FFFF_FFFF_FFFE + 64'(i), op_tbl[i], 1'b0,
                    64'h8000_0100 + 64'(4 * i), md_tbl[i], xw_tbl[i], 32'h0000_0100 << i);
    end
    idleCycle("hold_end");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
